hash_table_arbiter: RTL and testbench

HASH_TABLE_ARBITER -- requirements
Module: hash_table_arbiter

---
 rtl/hash_table_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_hash_table_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_table_arbiter.sv
// -----------------------------------------------------------------------------
// hash_table_arbiter
//
// Round-robin front end that lets NUM_REQ requesters share a single hash-table
// engine. One transaction is in flight at a time. A new request is granted only
// when the table reports DONE. When a result is captured, the next request can
// be granted on the same edge, so back-to-back transactions leave no idle
// table cycle between them.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   grant_en        1 = new grants permitted
//   req_valid       per-requester request pending
//   req_op          per-requester op, 2 bits each (0 NOOP, 1 INSERT, 2 LOOKUP, 3 ERASE)
//   req_key         per-requester key, KEY_WIDTH bits each
//   req_value       per-requester insert value, VALUE_WIDTH bits each
//   req_ready       one-hot accept strobe (combinational, grant cycle only)
//   resp_valid      one-cycle response strobe
//   resp_id/op      requester and op that own the response
//   resp_value      value returned by the table
//   resp_success    success flag returned by the table
//   ht_op/key/
//   ht_value_in     registered command to the table
//   ht_value_out,
//   ht_success      table result, sampled in the table's DONE cycle
//   ht_state        table FSM state (0 IDLE, 1 SEARCHING, 2 INSERTING, 3 DONE)
//   idle            no transaction in flight
//   op_count        accepted transactions (wraps)
//   fail_count      completed transactions with success=0 (wraps)
//   max_latency     longest observed table latency, in non-DONE cycles
// -----------------------------------------------------------------------------
module hash_table_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 64,
    parameter int IDW         = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           grant_en,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key,
    input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           resp_valid,
    output logic [IDW-1:0]                 resp_id,
    output logic [1:0]                     resp_op,
    output logic [VALUE_WIDTH-1:0]         resp_value,
    output logic                           resp_success,
    output logic [1:0]                     ht_op,
    output logic [KEY_WIDTH-1:0]           ht_key,
    output logic [VALUE_WIDTH-1:0]         ht_value_in,
    input  logic [VALUE_WIDTH-1:0]         ht_value_out,
    input  logic                           ht_success,
    input  logic [1:0]                     ht_state,
    output logic                           idle,
    output logic [31:0]                    op_count,
    output logic [31:0]                    fail_count,
    output logic [15:0]                    max_latency
);

    localparam logic [1:0]  OP_NOOP     = 2'd0;
    localparam logic [1:0]  HT_DONE     = 2'd3;
    localparam logic [15:0] LAT_MAX     = 16'hFFFF;
    localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   cur_id;
    logic [1:0]       cur_op;
    logic [15:0]      latency;

    logic             table_done;
    logic             result;
    logic             grant;

    // Per-requester views of the flattened request buses.
    logic [1:0]             op_arr  [NUM_REQ];
    logic [KEY_WIDTH-1:0]   key_arr [NUM_REQ];
    logic [VALUE_WIDTH-1:0] val_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g]  = req_op[2*g +: 2];
        assign key_arr[g] = req_key[KEY_WIDTH*g +: KEY_WIDTH];
        assign val_arr[g] = req_value[VALUE_WIDTH*g +: VALUE_WIDTH];
    end

    // Round-robin pick: first valid requester starting just after 'last'.
    // When nothing is valid the result is unused, so 'last' is returned.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDW-1:0]     last);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && valid[IDW'(idx)]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // The table only returns to DONE once per transaction, so any DONE seen
    // while busy is this transaction's result cycle.
    assign table_done = (ht_state == HT_DONE);
    assign result     = (state == S_BUSY) && table_done;
    assign grant      = !rst && table_done && grant_en && (|req_valid)
                        && ((state == S_IDLE) || result);
    assign winner     = rr_pick(req_valid, last_grant);
    assign idle       = (state == S_IDLE);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (grant) begin
            state_next = S_BUSY;
        end else if (result) begin
            state_next = S_IDLE;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from the values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Table command and transaction bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            ht_op       <= OP_NOOP;
            ht_key      <= '0;
            ht_value_in <= '0;
            cur_id      <= '0;
            cur_op      <= OP_NOOP;
            last_grant  <= LAST_RST;
            latency     <= '0;
            op_count    <= '0;
        end else begin
            if (state == S_BUSY && !table_done && latency != LAT_MAX) begin
                latency <= latency + 16'd1;
            end

            if (grant) begin
                ht_op       <= op_arr[winner];
                ht_key      <= key_arr[winner];
                ht_value_in <= val_arr[winner];
                cur_id      <= winner;
                cur_op      <= op_arr[winner];
                last_grant  <= winner;
                latency     <= '0;
                op_count    <= op_count + 32'd1;
            end else if (result) begin
                // Nothing follows: park the table on NOOP so it free-runs.
                ht_op <= OP_NOOP;
            end
        end
    end

    // Response capture and result statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_op      <= OP_NOOP;
            resp_value   <= '0;
            resp_success <= 1'b0;
            fail_count   <= '0;
            max_latency  <= '0;
        end else begin
            resp_valid <= result;
            if (result) begin
                resp_id      <= cur_id;
                resp_op      <= cur_op;
                resp_value   <= ht_value_out;
                resp_success <= ht_success;
                if (!ht_success) begin
                    fail_count <= fail_count + 32'd1;
                end
                if (latency > max_latency) begin
                    max_latency <= latency;
                end
            end
        end
    end

endmodule

// File: tb/tb_hash_table_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hash_table_arbiter
//
// Drives hash_table_arbiter against a small behavioural hash-table engine and
// compares the arbiter's outputs with a transaction-level model every cycle.
// Directed scenarios add literal expectations on grant order, timing and
// response contents.
// -----------------------------------------------------------------------------
module tb_hash_table_arbiter;

    localparam int N  = 4;
    localparam int KW = 32;
    localparam int VW = 64;

    localparam logic [1:0] NOOP = 2'd0, INSERT = 2'd1, LOOKUP = 2'd2, ERASE = 2'd3;
    localparam logic [1:0] T_IDLE = 2'd0, T_SEARCH = 2'd1, T_INS = 2'd2, T_DONE = 2'd3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            grant_en = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [2*N-1:0]  req_op = '0;
    logic [KW*N-1:0] req_key = '0;
    logic [VW*N-1:0] req_value = '0;

    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [1:0]      resp_op;
    logic [VW-1:0]   resp_value;
    logic            resp_success;
    logic [1:0]      ht_op;
    logic [KW-1:0]   ht_key;
    logic [VW-1:0]   ht_value_in;
    logic [VW-1:0]   ht_value_out;
    logic            ht_success;
    logic [1:0]      ht_state;
    logic            idle;
    logic [31:0]     op_count;
    logic [31:0]     fail_count;
    logic [15:0]     max_latency;

    always #5 clk = ~clk;

    hash_table_arbiter #(
        .NUM_REQ(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .IDW(2)
    ) dut (
        .clk(clk), .rst(rst), .grant_en(grant_en),
        .req_valid(req_valid), .req_op(req_op), .req_key(req_key), .req_value(req_value),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id), .resp_op(resp_op),
        .resp_value(resp_value), .resp_success(resp_success),
        .ht_op(ht_op), .ht_key(ht_key), .ht_value_in(ht_value_in),
        .ht_value_out(ht_value_out), .ht_success(ht_success), .ht_state(ht_state),
        .idle(idle), .op_count(op_count), .fail_count(fail_count), .max_latency(max_latency)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    bit hold_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural hash-table engine ----------------
    // DONE -> IDLE; IDLE with NOOP -> DONE; otherwise SEARCHING, then
    // INSERTING for inserts, then DONE with the result.
    logic [VW-1:0] mem [logic [KW-1:0]];
    logic [1:0]    t_op;
    logic [KW-1:0] t_key;
    logic [VW-1:0] t_vin;

    always @(posedge clk) begin
        if (rst) begin
            ht_state     <= T_DONE;
            ht_value_out <= '0;
            ht_success   <= 1'b0;
        end else begin
            case (ht_state)
                T_DONE: ht_state <= T_IDLE;
                T_IDLE: begin
                    if (ht_op == NOOP) begin
                        ht_state     <= T_DONE;
                        ht_value_out <= '0;
                        ht_success   <= 1'b0;
                    end else begin
                        ht_state <= T_SEARCH;
                        t_op     <= ht_op;
                        t_key    <= ht_key;
                        t_vin    <= ht_value_in;
                    end
                end
                T_SEARCH: begin
                    if (t_op == INSERT) begin
                        ht_state <= T_INS;
                    end else begin
                        ht_state     <= T_DONE;
                        ht_success   <= (mem.exists(t_key) != 0);
                        ht_value_out <= (t_op == LOOKUP && mem.exists(t_key) != 0) ? mem[t_key] : '0;
                        if (t_op == ERASE && mem.exists(t_key) != 0) mem.delete(t_key);
                    end
                end
                default: begin
                    mem[t_key] = t_vin;
                    ht_state     <= T_DONE;
                    ht_success   <= 1'b1;
                    ht_value_out <= t_vin;
                end
            endcase
        end
    end

    // ---------------- event logs taken from the DUT ----------------
    typedef struct { int cyc; int id; } grant_t;
    typedef struct { int cyc; int id; logic [1:0] op; logic [VW-1:0] value; logic success; } resp_t;

    grant_t     grant_q[$];
    resp_t      resp_q[$];
    logic [1:0] st_q[$];

    function automatic grant_t g_at(input int k);
        grant_t g;
        g.cyc = -1;
        g.id  = -1;
        if (k < grant_q.size()) g = grant_q[k];
        return g;
    endfunction

    function automatic resp_t r_at(input int k);
        resp_t r;
        r.cyc = -1; r.id = -1; r.op = 2'bxx; r.value = 'x; r.success = 1'bx;
        if (k < resp_q.size()) r = resp_q[k];
        return r;
    endfunction

    // ---------------- transaction-level reference model ----------------
    bit          m_ok = 1'b0;
    bit          m_busy;
    int          m_last, m_lat, m_max, m_cur_id;
    logic [31:0] m_ops, m_fails;
    logic [1:0]  m_cur_op, m_ht_op;
    logic [KW-1:0] m_key;
    logic [VW-1:0] m_val;
    bit          m_rv;
    int          m_rid;
    logic [1:0]  m_rop;
    logic [VW-1:0] m_rval;
    logic        m_rs;

    // Requester that wins this cycle, or -1 if no grant may happen.
    function automatic int winner_now();
        if (rst || ht_state != T_DONE || !grant_en) return -1;
        for (int j = 1; j <= N; j++) begin
            int id;
            id = (m_last + j) % N;
            if (req_valid[2'(id)]) return id;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : compare
        int w;
        bit res;
        logic [N-1:0] exp_ready;
        w = winner_now();
        exp_ready = (w < 0) ? '0 : (N'(1) << w);

        if (m_ok) begin
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("resp_valid", 64'(resp_valid), 64'(m_rv));
            check("idle", 64'(idle), 64'(!m_busy));
            check("ht_op", 64'(ht_op), 64'(m_ht_op));
            check("op_count", 64'(op_count), 64'(m_ops));
            check("fail_count", 64'(fail_count), 64'(m_fails));
            check("max_latency", 64'(max_latency), 64'(m_max));
            if (m_rv) begin
                check("resp_id", 64'(resp_id), 64'(m_rid));
                check("resp_op", 64'(resp_op), 64'(m_rop));
                check("resp_value", resp_value, m_rval);
                check("resp_success", 64'(resp_success), 64'(m_rs));
            end
            if (m_busy) begin
                check("ht_key", 64'(ht_key), 64'(m_key));
                check("ht_value_in", ht_value_in, m_val);
            end
        end

        for (int i = 0; i < N; i++) begin
            if (req_ready[i] === 1'b1) grant_q.push_back('{cyc, i});
        end
        if (resp_valid === 1'b1)
            resp_q.push_back('{cyc, int'(resp_id), resp_op, resp_value, resp_success});
        st_q.push_back(ht_state);

        if (rst) begin
            m_ok = 1'b1; m_busy = 1'b0; m_last = N - 1; m_lat = 0; m_max = 0;
            m_ops = '0; m_fails = '0; m_ht_op = NOOP; m_key = '0; m_val = '0;
            m_cur_id = 0; m_cur_op = NOOP;
            m_rv = 1'b0; m_rid = 0; m_rop = NOOP; m_rval = '0; m_rs = 1'b0;
        end else if (m_ok) begin
            res  = m_busy && (ht_state == T_DONE);
            m_rv = res;
            if (res) begin
                m_rid  = m_cur_id;
                m_rop  = m_cur_op;
                m_rval = ht_value_out;
                m_rs   = ht_success;
                if (!ht_success) m_fails = m_fails + 1;
                if (m_lat > m_max) m_max = m_lat;
            end
            if (m_busy && ht_state != T_DONE && m_lat < 65535) m_lat++;
            if (w >= 0) begin
                m_busy   = 1'b1;
                m_lat    = 0;
                m_ops    = m_ops + 1;
                m_last   = w;
                m_cur_id = w;
                m_cur_op = req_op[2*w +: 2];
                m_ht_op  = req_op[2*w +: 2];
                m_key    = req_key[KW*w +: KW];
                m_val    = req_value[VW*w +: VW];
            end else if (res) begin
                m_busy  = 1'b0;
                m_ht_op = NOOP;
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    // One clock: sample ready mid-cycle, then after the edge drop the
    // requests that were just accepted.
    task automatic step();
        logic [N-1:0] r;
        @(negedge clk);
        r = req_ready;
        @(posedge clk);
        #1;
        if (!hold_valid) req_valid = req_valid & ~r;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [KW-1:0] key,
                           input logic [VW-1:0] val);
        req_op[2*i +: 2]     = op;
        req_key[KW*i +: KW]  = key;
        req_value[VW*i +: VW] = val;
        req_valid[i]         = 1'b1;
    endtask

    task automatic do_reset(input bit clear_logs);
        rst = 1'b1;
        req_valid = '0;
        grant_en = 1'b1;
        hold_valid = 1'b0;
        repeat (2) step();
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_fail_count", 64'(fail_count), 64'd0);
        check("rst_max_latency", 64'(max_latency), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_ht_op", 64'(ht_op), 64'd0);
        rst = 1'b0;
        t0 = cyc;
        if (clear_logs) begin
            grant_q.delete();
            resp_q.delete();
            st_q.delete();
        end
    endtask

    task automatic drain(input int n, input int budget, input string tag);
        int b;
        b = 0;
        while (resp_q.size() < n && b < budget) begin
            step();
            b++;
        end
        check(tag, 64'(resp_q.size() >= n), 64'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int tg;
        int b;
        mem[32'd5] = 64'hAB;

        // Single LOOKUP right after reset; key 5 sits at the chain head.
        do_reset(1'b1);
        set_req(0, LOOKUP, 32'd5, '0);
        drain(1, 20, "t1_resp_seen");
        check("t1_grants", 64'(grant_q.size()), 64'd1);
        check("t1_grant_cyc", 64'(g_at(0).cyc - t0), 64'd0);
        check("t1_grant_id", 64'(g_at(0).id), 64'd0);
        check("t1_state1", 64'(st_q[1]), 64'(T_IDLE));
        check("t1_state2", 64'(st_q[2]), 64'(T_SEARCH));
        check("t1_state3", 64'(st_q[3]), 64'(T_DONE));
        check("t1_resp_cyc", 64'(r_at(0).cyc - t0), 64'd4);
        check("t1_resp_id", 64'(r_at(0).id), 64'd0);
        check("t1_resp_value", r_at(0).value, 64'hAB);
        check("t1_resp_success", 64'(r_at(0).success), 64'd1);
        check("t1_max_latency", 64'(max_latency), 64'd2);

        // All four INSERT at once: grants 0..3 back-to-back, 4 cycles apart.
        do_reset(1'b1);
        for (int i = 0; i < N; i++) set_req(i, INSERT, KW'(i), VW'(i));
        drain(4, 60, "t2_resp_seen");
        check("t2_grants", 64'(grant_q.size()), 64'd4);
        for (int k = 0; k < N; k++) begin
            check("t2_grant_id", 64'(g_at(k).id), 64'(k));
            check("t2_grant_cyc", 64'(g_at(k).cyc - t0), 64'(4 * k));
            check("t2_resp_id", 64'(r_at(k).id), 64'(k));
            check("t2_resp_success", 64'(r_at(k).success), 64'd1);
        end
        check("t2_op_count", 64'(op_count), 64'd4);
        check("t2_max_latency", 64'(max_latency), 64'd3);

        // Requesters 1 and 3 always valid: grants alternate 1,3,1,3...
        do_reset(1'b1);
        hold_valid = 1'b1;
        set_req(1, LOOKUP, 32'd7, '0);
        set_req(3, LOOKUP, 32'd7, '0);
        repeat (30) step();
        hold_valid = 1'b0;
        req_valid = '0;
        repeat (6) step();
        check("t3_enough_grants", 64'(grant_q.size() >= 6), 64'd1);
        for (int k = 0; k < 6; k++) begin
            check("t3_grant_id", 64'(g_at(k).id), (k % 2 == 0) ? 64'd1 : 64'd3);
            check("t3_grant_cyc", 64'(g_at(k).cyc - t0), 64'(3 * k));
        end

        // Absent key: LOOKUP then ERASE both fail; then a granted NOOP.
        do_reset(1'b1);
        set_req(2, LOOKUP, 32'd99, '0);
        drain(1, 20, "t4_lookup_seen");
        set_req(2, ERASE, 32'd99, '0);
        drain(2, 20, "t4_erase_seen");
        check("t4_lookup_op", 64'(r_at(0).op), 64'(LOOKUP));
        check("t4_lookup_success", 64'(r_at(0).success), 64'd0);
        check("t4_lookup_value", r_at(0).value, 64'd0);
        check("t4_erase_op", 64'(r_at(1).op), 64'(ERASE));
        check("t4_erase_success", 64'(r_at(1).success), 64'd0);
        check("t4_erase_value", r_at(1).value, 64'd0);
        check("t4_fail_count", 64'(fail_count), 64'd2);
        set_req(1, NOOP, 32'd1, 64'd1);
        drain(3, 20, "t4_noop_seen");
        check("t4_noop_id", 64'(r_at(2).id), 64'd1);
        check("t4_noop_op", 64'(r_at(2).op), 64'd0);
        check("t4_noop_success", 64'(r_at(2).success), 64'd0);
        check("t4_noop_ops", 64'(op_count), 64'd3);
        check("t4_noop_fails", 64'(fail_count), 64'd3);
        check("t4_noop_latency", 64'(max_latency), 64'd2);

        // grant_en low holds off a valid request; raising it grants at once.
        do_reset(1'b1);
        grant_en = 1'b0;
        set_req(2, LOOKUP, 32'd5, '0);
        repeat (20) step();
        check("t5_no_grant", 64'(grant_q.size()), 64'd0);
        check("t5_ht_op", 64'(ht_op), 64'd0);
        check("t5_idle", 64'(idle), 64'd1);
        grant_en = 1'b1;
        tg = cyc;
        b = 0;
        while (grant_q.size() == 0 && b < 5) begin
            step();
            b++;
        end
        check("t5_grant_id", 64'(g_at(0).id), 64'd2);
        check("t5_grant_prompt", 64'(g_at(0).cyc >= tg && g_at(0).cyc - tg <= 1), 64'd1);
        drain(1, 20, "t5_resp_seen");
        check("t5_resp_value", r_at(0).value, 64'hAB);

        // Reset while the table is SEARCHING: no response, counters cleared,
        // and the next request is granted in the first cycle after reset.
        do_reset(1'b1);
        set_req(0, LOOKUP, 32'd5, '0);
        step();
        step();
        check("t6_searching", 64'(ht_state), 64'(T_SEARCH));
        check("t6_busy", 64'(idle), 64'd0);
        do_reset(1'b0);
        set_req(1, LOOKUP, 32'd5, '0);
        drain(1, 20, "t6_resp_seen");
        check("t6_resp_count", 64'(resp_q.size()), 64'd1);
        check("t6_resp_id", 64'(r_at(0).id), 64'd1);
        check("t6_grants", 64'(grant_q.size()), 64'd2);
        check("t6_regrant_id", 64'(g_at(1).id), 64'd1);
        check("t6_regrant_cyc", 64'(g_at(1).cyc - t0), 64'd0);
        check("t6_op_count", 64'(op_count), 64'd1);
        check("t6_fail_count", 64'(fail_count), 64'd0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
